// File: rtl/l1_noc1_req_encoder_if.sv
// Request and NoC1 flit channels of the L1-to-L2 request encoder.
// The "master" modport is the request producer, which is also the flit consumer.
// The "slave" modport is the encoder itself.
interface l1_noc1_req_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_type;
  logic [5:0]  req_source;
  logic [25:0] req_tag;
  logic [63:0] req_data;
  logic        req_has_data;
  logic        noc_valid;
  logic [63:0] noc_data;
  logic        noc_ready;

  modport master (
    output req_valid, req_type, req_source, req_tag, req_data, req_has_data,
    output noc_ready,
    input  req_ready, noc_valid, noc_data
  );

  modport slave (
    input  req_valid, req_type, req_source, req_tag, req_data, req_has_data,
    input  noc_ready,
    output req_ready, noc_valid, noc_data
  );
endinterface

// File: rtl/l1_noc1_req_encoder.sv
// NoC1 request transmitter. It accepts one abstract request per handshake and
// serializes it into header, address, source-ID and optional data flits.
// It counts completed messages.
module l1_noc1_req_encoder #(
  parameter logic [3:0] FBITS   = 4'b0000,
  parameter logic [5:0] OPTION1 = 6'd0,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  l1_noc1_req_encoder_if.slave bus,
  input  logic [13:0]      dst_chipid,
  input  logic [7:0]       dst_x,
  input  logic [7:0]       dst_y,
  input  logic [13:0]      src_chipid,
  input  logic [7:0]       src_x,
  input  logic [7:0]       src_y,
  output logic             busy,
  output logic [CNT_W-1:0] tx_msg_count
);

  typedef enum logic [2:0] {IDLE, HDR, ADDR, SRC, DATA} state_t;

  state_t             state_reg, state_next;
  logic [63:0]        noc_data_reg, noc_data_next;
  logic [CNT_W-1:0]   count_reg, count_next;

  // The header register itself carries the destination, type and source
  // fields, so only the fields of the later flits need holding registers.
  logic [25:0]        tag_reg;
  logic [63:0]        data_reg;
  logic               has_data_reg;
  logic [13:0]        src_chipid_reg;
  logic [7:0]         src_x_reg;
  logic [7:0]         src_y_reg;

  logic               accept;
  logic               flit_hs;
  logic [7:0]         hdr_len;
  logic [63:0]        hdr_flit;

  assign bus.req_ready = (state_reg == IDLE) && !rst;
  assign bus.noc_valid = (state_reg != IDLE);
  assign bus.noc_data  = noc_data_reg;
  assign busy          = (state_reg != IDLE);
  assign tx_msg_count  = count_reg;

  assign accept   = bus.req_valid && bus.req_ready;
  assign flit_hs  = bus.noc_valid && bus.noc_ready;
  assign hdr_len  = bus.req_has_data ? 8'd3 : 8'd2;
  assign hdr_flit = {dst_chipid, dst_x, dst_y, FBITS, hdr_len,
                     bus.req_type, 2'b00, bus.req_source, OPTION1};

  // State register, presented flit and message counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      noc_data_reg <= 64'h0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      noc_data_reg <= noc_data_next;
      count_reg    <= count_next;
    end
  end

  // Next state. On each flit handshake, load the content of the next flit.
  always_comb begin
    state_next    = state_reg;
    noc_data_next = noc_data_reg;
    count_next    = count_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next    = HDR;
          noc_data_next = hdr_flit;
        end
      end
      HDR: begin
        if (flit_hs) begin
          state_next    = ADDR;
          noc_data_next = {24'b0, tag_reg, 14'b0};
        end
      end
      ADDR: begin
        if (flit_hs) begin
          state_next    = SRC;
          noc_data_next = {src_chipid_reg, src_x_reg, src_y_reg, 34'b0};
        end
      end
      SRC: begin
        if (flit_hs) begin
          if (has_data_reg) begin
            state_next    = DATA;
            noc_data_next = data_reg;
          end else begin
            state_next    = IDLE;
            noc_data_next = 64'h0;
            count_next    = count_reg + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (flit_hs) begin
          state_next    = IDLE;
          noc_data_next = 64'h0;
          count_next    = count_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next    = IDLE;
        noc_data_next = 64'h0;
      end
    endcase
  end

  // Capture request fields for the later flits, only when a request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg        <= '0;
      data_reg       <= '0;
      has_data_reg   <= 1'b0;
      src_chipid_reg <= '0;
      src_x_reg      <= '0;
      src_y_reg      <= '0;
    end else if (accept) begin
      tag_reg        <= bus.req_tag;
      data_reg       <= bus.req_data;
      has_data_reg   <= bus.req_has_data;
      src_chipid_reg <= src_chipid;
      src_x_reg      <= src_x;
      src_y_reg      <= src_y;
    end
  end

endmodule

// File: tb/tb_l1_noc1_req_encoder.sv
// Directed bench for l1_noc1_req_encoder. The expected flits are hand-computed constants.
module tb_l1_noc1_req_encoder;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic [13:0] dst_chipid, src_chipid;
  logic [7:0]  dst_x, dst_y, src_x, src_y;
  logic        busy;
  logic [CNT_W-1:0] tx_msg_count;

  int n_cmp = 0;
  int n_err = 0;

  l1_noc1_req_encoder_if bus_if ();

  l1_noc1_req_encoder #(.FBITS(4'b0000), .OPTION1(6'd0), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .dst_chipid   (dst_chipid),
    .dst_x        (dst_x),
    .dst_y        (dst_y),
    .src_chipid   (src_chipid),
    .src_x        (src_x),
    .src_y        (src_y),
    .busy         (busy),
    .tx_msg_count (tx_msg_count)
  );

  always #5 clk = ~clk;

  // Message 1: 2-flit message.
  localparam logic [63:0] M1_HDR  = 64'h0000_0408_0083_8140;
  localparam logic [63:0] M1_ADDR = 64'h0000_0048_D159_C000;
  localparam logic [63:0] M1_SRC  = 64'h0000_0C10_0000_0000;
  // Message 2: 3-flit message with data.
  localparam logic [63:0] M2_HDR  = 64'h0006_A954_00C4_0FC0;
  localparam logic [63:0] M2_ADDR = 64'h0000_00FF_FFFF_C000;
  localparam logic [63:0] M2_SRC  = 64'hFFFC_03FC_0000_0000;
  localparam logic [63:0] M2_DATA = 64'hDEAD_BEEF_CAFE_F00D;
  // Message 3: 2-flit message used for the backpressure test.
  localparam logic [63:0] M3_HDR  = 64'h0000_0000_0080_4000;
  localparam logic [63:0] M3_ADDR = 64'h0000_0000_02AF_0000;
  localparam logic [63:0] M3_SRC  = 64'h0008_0000_0000_0000;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_m1();
    bus_if.req_type = 8'h0E; bus_if.req_source = 6'h05; bus_if.req_tag = 26'h1234567;
    bus_if.req_has_data = 1'b0; bus_if.req_data = 64'h1111_2222_3333_4444;
    dst_chipid = 14'd0; dst_x = 8'd1; dst_y = 8'd2;
    src_chipid = 14'd0; src_x = 8'd3; src_y = 8'd4;
  endtask

  task automatic set_m2();
    bus_if.req_type = 8'h10; bus_if.req_source = 6'h3F; bus_if.req_tag = 26'h3FFFFFF;
    bus_if.req_has_data = 1'b1; bus_if.req_data = 64'hDEAD_BEEF_CAFE_F00D;
    dst_chipid = 14'h0001; dst_x = 8'hAA; dst_y = 8'h55;
    src_chipid = 14'h3FFF; src_x = 8'h00; src_y = 8'hFF;
  endtask

  task automatic set_m3();
    bus_if.req_type = 8'h01; bus_if.req_source = 6'h00; bus_if.req_tag = 26'h0000ABC;
    bus_if.req_has_data = 1'b0; bus_if.req_data = 64'h0;
    dst_chipid = 14'd0; dst_x = 8'd0; dst_y = 8'd0;
    src_chipid = 14'h0002; src_x = 8'd0; src_y = 8'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus_if.noc_ready = 1'b1;
    bus_if.req_valid = 1'b1;
    set_m1();

    // Hold reset with a request pending. Nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_noc_valid", bus_if.noc_valid, 1'b0);
      chk("rst_req_ready", bus_if.req_ready, 1'b0);
    end
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", tx_msg_count, 4'd0);
    chk("rst_noc_data", bus_if.noc_data, 64'h0);
    rst = 1'b0;
    bus_if.req_valid = 1'b0;
    cyc();
    chk("post_rst_req_ready", bus_if.req_ready, 1'b1);
    chk("post_rst_noc_valid", bus_if.noc_valid, 1'b0);

    // Message 1: 2-flit message, noc_ready=1.
    set_m1();
    bus_if.req_valid = 1'b1;
    cyc();
    bus_if.req_valid = 1'b0;
    chk("m1_hdr_valid", bus_if.noc_valid, 1'b1);
    chk("m1_hdr", bus_if.noc_data, M1_HDR);
    chk("m1_busy_req_ready", {busy, bus_if.req_ready}, 2'b10);
    cyc();
    chk("m1_addr", bus_if.noc_data, M1_ADDR);
    chk("m1_addr_valid", bus_if.noc_valid, 1'b1);
    cyc();
    chk("m1_src", bus_if.noc_data, M1_SRC);
    chk("m1_src_valid", bus_if.noc_valid, 1'b1);
    cyc();
    chk("m1_end_valid", bus_if.noc_valid, 1'b0);
    chk("m1_end_req_ready", bus_if.req_ready, 1'b1);
    chk("m1_count", tx_msg_count, 4'd1);

    // Message 2: 3-flit message with data.
    set_m2();
    bus_if.req_valid = 1'b1;
    cyc();
    bus_if.req_valid = 1'b0;
    chk("m2_hdr", bus_if.noc_data, M2_HDR);
    cyc();
    chk("m2_addr", bus_if.noc_data, M2_ADDR);
    cyc();
    chk("m2_src", bus_if.noc_data, M2_SRC);
    cyc();
    chk("m2_data", bus_if.noc_data, M2_DATA);
    chk("m2_data_valid", bus_if.noc_valid, 1'b1);
    chk("m2_data_req_ready", bus_if.req_ready, 1'b0);
    cyc();
    chk("m2_end_req_ready", bus_if.req_ready, 1'b1);
    chk("m2_count", tx_msg_count, 4'd2);

    // Message 3: backpressure, with noc_ready low for two cycles during ADDR.
    set_m3();
    bus_if.req_valid = 1'b1;
    cyc();
    bus_if.req_valid = 1'b0;
    chk("m3_hdr", bus_if.noc_data, M3_HDR);
    cyc();
    bus_if.noc_ready = 1'b0;
    set_m1();
    chk("m3_addr0", bus_if.noc_data, M3_ADDR);
    cyc();
    chk("m3_addr1", bus_if.noc_data, M3_ADDR);
    chk("m3_addr1_valid", bus_if.noc_valid, 1'b1);
    cyc();
    chk("m3_addr2", bus_if.noc_data, M3_ADDR);
    bus_if.noc_ready = 1'b1;
    cyc();
    chk("m3_src", bus_if.noc_data, M3_SRC);
    cyc();
    chk("m3_end_valid", bus_if.noc_valid, 1'b0);
    chk("m3_count", tx_msg_count, 4'd3);

    // Back-to-back messages with req_valid held high. The inputs change mid-message.
    set_m1();
    bus_if.req_valid = 1'b1;
    cyc();
    set_m2();
    chk("b2b_a_hdr", bus_if.noc_data, M1_HDR);
    cyc();
    chk("b2b_a_addr", bus_if.noc_data, M1_ADDR);
    cyc();
    chk("b2b_a_src", bus_if.noc_data, M1_SRC);
    cyc();
    chk("b2b_bubble", {bus_if.noc_valid, bus_if.req_ready}, 2'b01);
    cyc();
    bus_if.req_valid = 1'b0;
    set_m3();
    chk("b2b_b_hdr", bus_if.noc_data, M2_HDR);
    cyc();
    chk("b2b_b_addr", bus_if.noc_data, M2_ADDR);
    cyc();
    chk("b2b_b_src", bus_if.noc_data, M2_SRC);
    cyc();
    chk("b2b_b_data", bus_if.noc_data, M2_DATA);
    cyc();
    chk("b2b_count", tx_msg_count, 4'd5);

    // Counter wrap: 11 more 2-flit messages at 4 cycles each bring the count 5 -> 16 -> 0.
    set_m1();
    bus_if.req_valid = 1'b1;
    for (int i = 0; i < 44; i++) begin
      cyc();
      if (i == 39) chk("wrap_count15", tx_msg_count, 4'd15);
    end
    bus_if.req_valid = 1'b0;
    chk("wrap_count0", tx_msg_count, 4'd0);
    chk("wrap_idle", bus_if.noc_valid, 1'b0);

    // Send one message so that the count is nonzero before the mid-message reset.
    set_m3();
    bus_if.req_valid = 1'b1;
    cyc();
    bus_if.req_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("pre_rst_count", tx_msg_count, 4'd1);

    // Assert reset during SRC.
    set_m1();
    bus_if.req_valid = 1'b1;
    cyc();
    bus_if.req_valid = 1'b0;
    cyc();
    cyc();
    chk("mid_src", bus_if.noc_data, M1_SRC);
    rst = 1'b1;
    cyc();
    chk("mid_rst_valid", bus_if.noc_valid, 1'b0);
    chk("mid_rst_count", tx_msg_count, 4'd0);
    chk("mid_rst_busy", busy, 1'b0);
    rst = 1'b0;
    cyc();
    chk("mid_rst_stays_idle", bus_if.noc_valid, 1'b0);

    // After the reset, a new request encodes cleanly.
    set_m2();
    bus_if.req_valid = 1'b1;
    cyc();
    bus_if.req_valid = 1'b0;
    chk("post_hdr", bus_if.noc_data, M2_HDR);
    cyc();
    chk("post_addr", bus_if.noc_data, M2_ADDR);
    cyc();
    chk("post_src", bus_if.noc_data, M2_SRC);
    cyc();
    chk("post_data", bus_if.noc_data, M2_DATA);
    cyc();
    chk("post_count", tx_msg_count, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/l1_noc1_req_encoder.md
# l1_noc1_req_encoder

Request-side NoC1 transmitter that sits at the private-cache end of the L2 link and drives the 64-bit NoC1 flit stream the L2 consumes. It accepts one abstract request per handshake (type, source, tag, optional 64-bit data) and serializes it into a header, address, source-ID and optional data flit. It applies valid/ready backpressure on both sides and counts transmitted messages for bring-up checks.

## Interface
- FBITS, 4'b0000: final-destination bits in the header.
- OPTION1, 6'd0: header option field.
- CNT_W, 16: width of tx_msg_count.
- clk  in  1: clock; all state updates on rising edge.
- rst  in  1: synchronous, active-high reset.
- req_valid  in  1: request present.
- req_ready  out  1: encoder can accept a request.
- req_type  in  8: NoC message type.
- req_source  in  6: requester MSHR/source ID.
- req_tag  in  26: cache-line address (addr[39:14]).
- req_data  in  64: payload; used only when req_has_data=1.
- req_has_data  in  1: append the data flit.
- dst_chipid  in  14, dst_x  in  8, dst_y  in  8: L2 home-tile coordinates, sampled at accept.
- src_chipid  in  14, src_x  in  8, src_y  in  8: own-tile coordinates, sampled at accept.
- noc_valid  out  1: flit valid.
- noc_data  out  64: flit.
- noc_ready  in  1: downstream (L2 NoC1 input) accepts the flit.
- busy  out  1: message in flight (state != IDLE).
- tx_msg_count  out  CNT_W: completed messages, wraps.

## Operation
- FSM states: IDLE, HDR, ADDR, SRC, DATA.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - latch all req_* and coordinate inputs into holding registers;
  - go to HDR.
- Header flit, registered on accept:
  - [63:50] dst_chipid, [49:42] dst_x, [41:34] dst_y, [33:30] FBITS;
  - [29:22] payload length = 2 + req_has_data (2 or 3);
  - [21:14] req_type, [13:6] {2'b00, req_source}, [5:0] OPTION1.
- ADDR flit: {24'b0, tag, 14'b0}.
- SRC flit: {src_chipid, src_x, src_y, 34'b0}.
- DATA flit: req_data.
- Transitions, all on noc_valid&&noc_ready:
  - HDR→ADDR;
  - ADDR→SRC;
  - SRC→DATA if has_data, else →IDLE;
  - DATA→IDLE.
- noc_data is reloaded on each handshake with the next flit's content. Without a handshake, noc_valid and noc_data hold exactly.
- The last-flit handshake increments tx_msg_count by 1, modulo 2^CNT_W (all-ones wraps to 0).
- req_ready is a decode of state==IDLE. Requests are never accepted mid-message, and request inputs are ignored outside IDLE.
- noc_valid=1 in every non-IDLE state. No flit is ever withdrawn once presented.

## Timing
- Reset values:
  - state IDLE; req_ready=1 from the first cycle after rst deasserts (0 while rst=1);
  - noc_valid=0, noc_data=64'h0, busy=0, tx_msg_count=0;
  - holding registers are cleared.
- Latency: request accepted at edge T → header valid in cycle T+1.
- With noc_ready held at 1:
  - flits occupy cycles T+1..T+3 (2-flit message) or T+1..T+4 (3-flit message);
  - req_ready is 1 again in the cycle after the last flit;
  - sustained rate is one message per 4 or 5 cycles (one IDLE bubble).
- Backpressure: each cycle with noc_ready=0 stretches the current flit by exactly one cycle.
- rst mid-message: the partial message is abandoned. noc_valid falls to 0 the next cycle with no further flits, and tx_msg_count is cleared.
- Simultaneous events in IDLE: req_valid together with noc_ready has no interaction, because noc_valid=0 there.

## Test plan
- Reset: hold rst 3 cycles with req_valid=1 → noc_valid=0, req_ready=0 during reset, no request accepted; req_ready=1 in the first cycle after release.
- 2-flit message, noc_ready=1:
  - stimulus: type 8'h0E, source 6'h05, tag 26'h1234567, has_data=0, dst (0,1,2), src (0,3,4);
  - header: length 2, [21:14]=8'h0E, [13:6]=8'h05, [49:42]=1, [41:34]=2;
  - ADDR flit = {24'b0, 26'h1234567, 14'b0};
  - SRC flit [49:42]=3, [41:34]=4;
  - 3 consecutive valid cycles, then tx_msg_count=1.
- 3-flit message with data 64'hDEADBEEF_CAFEF00D → length 3; fourth flit equals that data; req_ready returns 1 five cycles after accept.
- Backpressure: noc_ready low 2 cycles during ADDR → ADDR flit held stable 3 cycles; SRC follows immediately after the handshake; no flit duplicated or skipped.
- Back-to-back requests with req_valid held high → exactly one IDLE cycle between messages; second message's fields are independent of the first's; inputs changed mid-message do not alter in-flight flits.
- Wrap and mid-message reset:
  - with CNT_W=4, send 16 messages → tx_msg_count returns to 0;
  - assert rst during SRC → noc_valid=0 next cycle, count 0, next request encodes cleanly.
